// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter:
// FSM states and transaction owner, also used by the LSU and memory model.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic state_e busy_of(owner_e o);
    return (o == OWN_D) ? ST_BUSY_D : ST_BUSY_I;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D).
// D has priority; a starvation counter forces an I grant after a D streak.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e        state;
  logic [CW-1:0] starve_cnt;
  logic          kill;

  logic   i_ok;
  logic   force_i;
  logic   grant_d;
  logic   grant_i;
  logic   st_d;
  owner_e winner;

  // A flushing fetch is never granted, even when it would be forced.
  always_comb begin
    i_ok    = if_req && !if_flush;
    force_i = i_ok && (starve_cnt == LIMIT);
    grant_d = d_req && !force_i;
    grant_i = i_ok && !grant_d;
    st_d    = grant_d && d_we;
    winner  = grant_d ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      kill       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_d || grant_i) begin
            state     <= busy_of(winner);
            mem_req   <= 1'b1;
            mem_we    <= st_d;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= st_d ? d_wdata : '0;
            mem_wstrb <= st_d ? d_wstrb : '0;
          end
          if (!if_req || grant_i)
            starve_cnt <= '0;
          else if (grant_d && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + CW'(1);
        end
        ST_BUSY_I: begin
          if (if_flush)
            kill <= 1'b1;
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= !(kill || if_flush);
            state    <= ST_RESP;
          end
        end
        ST_BUSY_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            d_rdata <= mem_rdata;
            d_done  <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          kill    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed corner
// sequences and a randomized transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // win: 0 = no grant, 1 = fetch, 2 = data
  typedef struct {
    logic        ir;
    logic        fl;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          k;
    logic [31:0] rd;
    int          win;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    if_req = v.ir; if_flush = v.fl; if_addr = v.ia;
    d_req = v.dr; d_we = v.we; d_addr = v.da;
    d_wdata = v.wd; d_wstrb = v.ws;
    @(negedge clk);
    if (v.win == 0) begin
      chk($sformatf("v%0d_nogrant", i), 32'(mem_req), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_nogrant2", i), 32'(mem_req), 32'd0);
      idle_inputs();
      @(negedge clk);
      return;
    end
    for (int j = 1; j <= v.k; j++) begin
      if (j > 1) @(negedge clk);
      chk($sformatf("v%0d_req_c%0d", i, j), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d_we_c%0d", i, j), 32'(mem_we), 32'(v.e_we));
      chk($sformatf("v%0d_addr_c%0d", i, j), mem_addr, v.e_addr);
      chk($sformatf("v%0d_wdata_c%0d", i, j), mem_wdata, v.e_wdata);
      chk($sformatf("v%0d_wstrb_c%0d", i, j), 32'(mem_wstrb),
          32'(v.e_wstrb));
      chk($sformatf("v%0d_nodone_c%0d", i, j),
          32'({if_done, d_done}), 32'd0);
      if (j == v.k) begin
        mem_ack = 1'b1;
        mem_rdata = v.rd;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk($sformatf("v%0d_ifdone", i), 32'(if_done), 32'(v.win == 1));
    chk($sformatf("v%0d_ddone", i), 32'(d_done), 32'(v.win == 2));
    chk($sformatf("v%0d_reqdrop", i), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d_rdata", i),
        (v.win == 1) ? if_rdata : d_rdata, v.rd);
    idle_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_pulse1", i), 32'({if_done, d_done}), 32'd0);
  endtask

  task automatic flush_case(input bit with_ack, input logic [31:0] rd);
    string p;
    p = with_ack ? "flack" : "flbusy";
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    chk({p, "_grant"}, 32'(mem_req), 32'd1);
    chk({p, "_addr"}, mem_addr, 32'h80);
    if (!with_ack) begin
      if_flush = 1'b1; if_req = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rd;
    end else begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rd;
      if_flush = 1'b1; if_req = 1'b0;
    end
    @(negedge clk);
    mem_ack = 1'b0; if_flush = 1'b0;
    chk({p, "_nodone"}, 32'(if_done), 32'd0);
    chk({p, "_rdata"}, if_rdata, rd);
    chk({p, "_reqdrop"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    chk({p, "_nodone2"}, 32'(if_done), 32'd0);
    if_req = 1'b1; if_addr = 32'h84;
    @(negedge clk);
    chk({p, "_next_grant"}, 32'(mem_req), 32'd1);
    chk({p, "_next_addr"}, mem_addr, 32'h84);
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({p, "_next_done"}, 32'(if_done), 32'd1);
    idle_inputs();
    @(negedge clk);
  endtask

  // Randomized run: requesters and memory are agents; expected
  // behaviour is tracked per transaction with cycle timestamps.
  task automatic random_run(input int ncyc);
    int   streak, free_at, mem_start, done_cyc, lat_left;
    bit   active, acked, exp_req, t_i, ok_i;
    logic [31:0] t_addr, t_wdata, t_rd;
    logic [3:0]  t_wstrb;
    logic        t_we;
    streak = 0; free_at = 0; active = 0; acked = 0;
    mem_start = 0; done_cyc = -1; lat_left = 0;
    t_i = 0; t_addr = '0; t_wdata = '0; t_rd = '0;
    t_wstrb = '0; t_we = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      exp_req = active && !acked && n >= mem_start;
      chk("rnd_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("rnd_addr", mem_addr, t_addr);
        chk("rnd_we", 32'(mem_we), 32'(t_we));
        chk("rnd_wdata", mem_wdata, t_wdata);
        chk("rnd_wstrb", 32'(mem_wstrb), 32'(t_wstrb));
      end
      if (active && acked && n == done_cyc) begin
        chk("rnd_ifdone", 32'(if_done), 32'(t_i));
        chk("rnd_ddone", 32'(d_done), 32'(!t_i));
        chk("rnd_rdata", t_i ? if_rdata : d_rdata, t_rd);
        active = 0;
        free_at = n + 1;
      end else begin
        chk("rnd_nodone", 32'({if_done, d_done}), 32'd0);
      end
      mem_ack = 1'b0;
      if (if_req && if_done) if_req = 1'b0;
      if (d_req && d_done) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(1, 15));
      end
      if (exp_req) begin
        if (lat_left <= 1) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom;
          t_rd = mem_rdata;
          acked = 1;
          done_cyc = n + 1;
        end else begin
          lat_left--;
        end
      end
      if (!active && n >= free_at) begin
        ok_i = if_req && !if_flush;
        if (!if_req) streak = 0;
        if (d_req && !(ok_i && streak == LIM)) begin
          active = 1; t_i = 0;
          t_we = d_we; t_addr = d_addr;
          t_wdata = d_we ? d_wdata : 32'h0;
          t_wstrb = d_we ? d_wstrb : 4'h0;
          if (if_req && streak < LIM) streak++;
        end else if (ok_i) begin
          active = 1; t_i = 1;
          t_we = 1'b0; t_addr = if_addr;
          t_wdata = '0; t_wstrb = '0;
          streak = 0;
        end
        if (active) begin
          acked = 0;
          mem_start = n + 1;
          lat_left = $urandom_range(1, 3);
        end
      end
    end
  endtask

  initial begin
    int order[10];
    int exp_order[10];
    int got, ifd, dd;

    idle_inputs();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_addr = 32'h100;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_mem_misc", 32'({mem_we, mem_wstrb}) | mem_wdata, 32'd0);
      chk("rst_done", 32'({if_done, d_done}), 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req", 32'(mem_req), 32'd1);
    chk("rel_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rel_ddone", 32'(d_done), 32'd1);
    chk("rel_rdata", d_rdata, 32'h11111111);
    idle_inputs();
    @(negedge clk);

    vt[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              1, 32'h00500093, 1, 1'b0, 32'h0, 32'h0, 4'h0};
    vt[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF,
              4'hF, 3, 32'h00000001, 2, 1'b1, 32'h200, 32'hDEADBEEF,
              4'hF};
    vt[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h12345678,
              4'h5, 2, 32'hA5A5A5A5, 2, 1'b0, 32'h300, 32'h0, 4'h0};
    vt[3] = '{1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h400, 32'h0BADF00D,
              4'h3, 1, 32'h00000002, 2, 1'b1, 32'h400, 32'h0BADF00D,
              4'h3};
    vt[4] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              1, 32'h0, 0, 1'b0, 32'h0, 32'h0, 4'h0};
    vt[5] = '{1'b1, 1'b1, 32'h48, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0,
              2, 32'h00000077, 2, 1'b0, 32'h500, 32'h0, 4'h0};
    vt[6] = '{1'b1, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 32'h0,
              4'h0, 3, 32'h00000013, 1, 1'b0, 32'hFFFFFFFC, 32'h0,
              4'h0};
    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    flush_case(1'b0, 32'hCAFE0001);
    flush_case(1'b1, 32'hCAFE0002);

    exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    got = 0; ifd = 0; dd = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 0; c < 200 && got < 10; c++) begin
      @(negedge clk);
      ifd += int'(if_done);
      dd += int'(d_done);
      mem_ack = mem_req;
      mem_rdata = 32'(c);
      if (mem_req) begin
        order[got] = (mem_addr == 32'h2000) ? 2 : 1;
        got++;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    ifd += int'(if_done);
    dd += int'(d_done);
    chk("starve_count", 32'(got), 32'd10);
    for (int i = 0; i < got; i++)
      chk($sformatf("starve_order_%0d", i), 32'(order[i]),
          32'(exp_order[i]));
    chk("starve_ifdones", 32'(ifd), 32'd2);
    chk("starve_ddones", 32'(dd), 32'd8);
    idle_inputs();
    repeat (2) @(negedge clk);

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(negedge clk);
    chk("mid_rst_busy", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_async_req", 32'(mem_req), 32'd0);
    chk("mid_rst_nodone", 32'(d_done), 32'd0);
    @(negedge clk);
    chk("mid_rst_held", 32'({mem_req, d_done}), 32'd0);
    d_addr = 32'h304;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h304);
    mem_ack = 1'b1; mem_rdata = 32'h0F0F0F0F;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("post_rst_ddone", 32'(d_done), 32'd1);
    chk("post_rst_rdata", d_rdata, 32'h0F0F0F0F);
    idle_inputs();
    @(negedge clk);

    do_reset();
    random_run(1500);

    idle_inputs();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
